// File: rtl/wb_regfile.sv
// Write-back stage + 32x32 register file with write-through bypass and a retired-write counter.
// Stage captures on falling edge, commits on the next rising edge; no backpressure, one entry per cycle.
module wb_regfile (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        RW,
  input  logic [4:0]  DA,
  input  logic [1:0]  MD,
  input  logic [31:0] F,
  input  logic [31:0] Data_Out,
  input  logic        VxorN,
  input  logic [4:0]  AA,
  input  logic [4:0]  BA,
  output logic [31:0] A_DATA,
  output logic [31:0] B_DATA,
  output logic [31:0] WB_DATA,
  output logic        WB_RW,
  output logic [4:0]  WB_DA,
  output logic [31:0] RETIRED
);

  logic        st_rw;
  logic [4:0]  st_da;
  logic [1:0]  st_md;
  logic [31:0] st_f;
  logic [31:0] st_dout;
  logic        st_vxn;

  logic [31:0] wb_data;
  logic        wb_rw;
  logic [31:0] regs [32];
  logic [31:0] retired_cnt;
  logic [31:0] a_data;
  logic [31:0] b_data;

  // Falling-edge capture matches the execute stage's launch edge.
  always_ff @(negedge CLOCK) begin
    if (RESET) begin
      st_rw   <= 1'b0;
      st_da   <= 5'd0;
      st_md   <= 2'd0;
      st_f    <= 32'd0;
      st_dout <= 32'd0;
      st_vxn  <= 1'b0;
    end else begin
      st_rw   <= RW;
      st_da   <= DA;
      st_md   <= MD;
      st_f    <= F;
      st_dout <= Data_Out;
      st_vxn  <= VxorN;
    end
  end

  always_comb begin
    case (st_md)
      2'b01:   wb_data = st_dout;
      2'b10:   wb_data = {31'd0, st_vxn};
      default: wb_data = st_f;
    endcase
  end

  assign wb_rw = st_rw & (st_da != 5'd0);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      retired_cnt <= 32'd0;
    end else if (wb_rw) begin
      regs[st_da] <= wb_data;
      retired_cnt <= retired_cnt + 32'd1;
    end
  end

  // Bypass keeps the staged value visible until the array holds it.
  always_comb begin
    a_data = 32'd0;
    if (AA != 5'd0) begin
      if (wb_rw && (AA == st_da)) a_data = wb_data;
      else                        a_data = regs[AA];
    end
  end

  always_comb begin
    b_data = 32'd0;
    if (BA != 5'd0) begin
      if (wb_rw && (BA == st_da)) b_data = wb_data;
      else                        b_data = regs[BA];
    end
  end

  assign A_DATA  = a_data;
  assign B_DATA  = b_data;
  assign WB_DATA = wb_data;
  assign WB_RW   = wb_rw;
  assign WB_DA   = st_da;
  assign RETIRED = retired_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: architectural model checked on every clock edge plus literal expectations.
module tb_wb_regfile;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        RW;
  logic [4:0]  DA;
  logic [1:0]  MD;
  logic [31:0] F;
  logic [31:0] Data_Out;
  logic        VxorN;
  logic [4:0]  AA;
  logic [4:0]  BA;
  logic [31:0] A_DATA;
  logic [31:0] B_DATA;
  logic [31:0] WB_DATA;
  logic        WB_RW;
  logic [4:0]  WB_DA;
  logic [31:0] RETIRED;

  wb_regfile dut (
    .CLOCK(CLOCK), .RESET(RESET), .RW(RW), .DA(DA), .MD(MD), .F(F),
    .Data_Out(Data_Out), .VxorN(VxorN), .AA(AA), .BA(BA),
    .A_DATA(A_DATA), .B_DATA(B_DATA), .WB_DATA(WB_DATA), .WB_RW(WB_RW),
    .WB_DA(WB_DA), .RETIRED(RETIRED)
  );

  initial forever #5 CLOCK = ~CLOCK;

  int n_chk  = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Architectural model: one pending write plus an array of committed values.
  logic [31:0] m_regs [32];
  logic        m_rw  = 1'b0;
  logic [4:0]  m_da  = 5'd0;
  logic [31:0] m_val = 32'd0;
  logic [31:0] m_ret = 32'd0;
  logic        m_clk = 1'b0;
  int          bd_seq  = 0;
  int          bd_seen = 0;
  logic [31:0] bd_val  = 32'd0;

  function automatic logic [31:0] exp_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
    if (m_rw && (m_da != 5'd0) && (addr == m_da)) return m_val;
    return m_regs[addr];
  endfunction

  always @(CLOCK or bd_seq) begin
    if (bd_seq != bd_seen) begin
      m_ret   = bd_val;
      bd_seen = bd_seq;
    end
    if (CLOCK !== m_clk) begin
      m_clk = CLOCK;
      if (CLOCK == 1'b0) begin
        if (RESET) begin
          m_rw = 1'b0; m_da = 5'd0; m_val = 32'd0;
        end else begin
          m_rw = RW;
          m_da = DA;
          if (MD == 2'b01)      m_val = Data_Out;
          else if (MD == 2'b10) m_val = VxorN ? 32'd1 : 32'd0;
          else                  m_val = F;
        end
      end else begin
        if (RESET) begin
          for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
          m_ret = 32'd0;
        end else if (m_rw && (m_da != 5'd0)) begin
          m_regs[m_da] = m_val;
          m_ret = m_ret + 32'd1;
        end
      end
    end
  end

  always @(CLOCK) begin
    #2;
    if (chk_en) begin
      check("a_data",  A_DATA,  exp_read(AA));
      check("b_data",  B_DATA,  exp_read(BA));
      check("wb_data", WB_DATA, m_val);
      check("wb_rw",   {31'd0, WB_RW}, {31'd0, m_rw && (m_da != 5'd0)});
      check("wb_da",   {27'd0, WB_DA}, {27'd0, m_da});
      check("retired", RETIRED, m_ret);
    end
  end

  task automatic idle();
    RW = 1'b0; DA = 5'd0; MD = 2'd0; F = 32'd0; Data_Out = 32'd0; VxorN = 1'b0;
  endtask

  task automatic drive(input logic [4:0] da, input logic [1:0] md, input logic [31:0] f,
                       input logic [31:0] dout, input logic vxn);
    RW = 1'b1; DA = da; MD = md; F = f; Data_Out = dout; VxorN = vxn;
  endtask

  task automatic wr(input logic [4:0] da, input logic [1:0] md, input logic [31:0] f,
                    input logic [31:0] dout, input logic vxn);
    drive(da, md, f, dout, vxn);
    @(negedge CLOCK); #2;
    @(posedge CLOCK); #1;
    idle();
  endtask

  initial begin
    RESET = 1'b1; AA = 5'd0; BA = 5'd0;
    idle();
    repeat (2) begin
      RW = 1'($urandom); DA = 5'($urandom); MD = 2'($urandom);
      F = $urandom; Data_Out = $urandom; VxorN = 1'($urandom);
      AA = 5'($urandom); BA = 5'($urandom);
      @(posedge CLOCK); #1;
    end
    RESET = 1'b0;
    idle();
    chk_en = 1'b1;
    #1;
    check("rst_wb_rw",   {31'd0, WB_RW}, 32'd0);
    check("rst_wb_da",   {27'd0, WB_DA}, 32'd0);
    check("rst_wb_data", WB_DATA, 32'd0);
    check("rst_retired", RETIRED, 32'd0);
    for (int i = 0; i < 32; i++) begin
      AA = 5'(i); BA = 5'(31 - i);
      #1;
      check("rst_a_zero", A_DATA, 32'd0);
      check("rst_b_zero", B_DATA, 32'd0);
      @(posedge CLOCK); #1;
    end

    // Basic write with bypass before commit and array read afterwards.
    AA = 5'd5;
    drive(5'd5, 2'b00, 32'h1234_5678, 32'h0, 1'b0);
    @(negedge CLOCK); #2;
    check("bypass_a5", A_DATA, 32'h1234_5678);
    check("retired_pre", RETIRED, 32'd0);
    @(posedge CLOCK); #1;
    idle();
    check("commit_a5", A_DATA, 32'h1234_5678);
    check("retired_1", RETIRED, 32'd1);
    @(negedge CLOCK); #2;
    check("array_a5", A_DATA, 32'h1234_5678);
    @(posedge CLOCK); #1;

    // Write-back select, with the unselected sources holding distinct values.
    wr(5'd7, 2'b01, 32'h1111_1111, 32'hDEAD_BEEF, 1'b0);
    wr(5'd8, 2'b10, 32'hFFFF_0000, 32'h2222_2222, 1'b1);
    wr(5'd9, 2'b11, 32'h0000_0055, 32'h0000_0099, 1'b1);
    @(negedge CLOCK); #2;
    AA = 5'd7; BA = 5'd8; #1;
    check("r7_md01", A_DATA, 32'hDEAD_BEEF);
    check("r8_md10", B_DATA, 32'h0000_0001);
    AA = 5'd9; #1;
    check("r9_md11", A_DATA, 32'h0000_0055);
    check("retired_4", RETIRED, 32'd4);
    @(posedge CLOCK); #1;

    // R0 write is neither committed nor bypassed.
    AA = 5'd0;
    drive(5'd0, 2'b00, 32'hFFFF_FFFF, 32'h0, 1'b0);
    @(negedge CLOCK); #2;
    check("r0_wb_rw", {31'd0, WB_RW}, 32'd0);
    check("r0_a", A_DATA, 32'd0);
    @(posedge CLOCK); #1;
    idle();
    check("r0_retired", RETIRED, 32'd4);

    // Back-to-back writes to R3, with R5 read alongside as an unrelated address.
    BA = 5'd3; AA = 5'd5;
    for (int v = 1; v <= 3; v++) begin
      drive(5'd3, 2'b00, 32'(v), 32'h0, 1'b0);
      @(negedge CLOCK); #2;
      check("b2b_b3", B_DATA, 32'(v));
      check("b2b_a5", A_DATA, 32'h1234_5678);
      @(posedge CLOCK); #1;
    end
    idle();
    check("b2b_retired", RETIRED, 32'd7);

    // Reset while a write is staged discards it.
    RESET = 1'b1;
    drive(5'd4, 2'b00, 32'h0000_00AA, 32'h0, 1'b0);
    @(negedge CLOCK); #2;
    check("rst_mid_wb_rw", {31'd0, WB_RW}, 32'd0);
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    idle();
    AA = 5'd4; BA = 5'd3; #1;
    check("rst_mid_r4", A_DATA, 32'd0);
    check("rst_mid_r3", B_DATA, 32'd0);
    check("rst_mid_retired", RETIRED, 32'd0);
    @(posedge CLOCK); #1;

    // Counter wrap through a backdoor preset.
    bd_val = 32'hFFFF_FFFF;
    dut.retired_cnt = 32'hFFFF_FFFF;
    bd_seq = bd_seq + 1;
    AA = 5'd10;
    wr(5'd10, 2'b00, 32'h0000_0077, 32'h0, 1'b0);
    check("wrap_retired", RETIRED, 32'd0);
    check("wrap_r10", A_DATA, 32'h0000_0077);

    repeat (3) begin @(posedge CLOCK); #1; end
    chk_en = 1'b0;
    #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
